// File: rtl/huffman_decoder.sv
// Purpose : bit-serial canonical Huffman decoder; tables (count per code length,
//           symbols in canonical order) are loaded through a config write port.
// Latency : sym_valid rises one cycle after the last bit of a code is accepted.
// Backpres: while a symbol waits for sym_ready the bit input is stalled
//           (bit_ready = 0); bit acceptance also stalls during any table write.
// Ports   : CLK, RST (async, active-high); cfg_we/cfg_sel/cfg_addr/cfg_data table
//           writes (sel 0 = count[1..MAX_LEN], sel 1 = sym[0..NSYM-1]); start
//           re-aligns to a code boundary; bit_in/bit_valid/bit_ready coded input;
//           sym_out/sym_valid/sym_ready decoded output; err sticky error; busy.
module huffman_decoder #(
    parameter int MAX_LEN = 8,
    parameter int NSYM    = 16,
    parameter int SYM_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [3:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             err,
    output logic             busy
);

    localparam int CW    = MAX_LEN + 1;          // code/first/index width
    localparam int XW    = CW + 1;               // one guard bit for sums
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int SA_W  = $clog2(NSYM);

    localparam logic [1:0] S_BIT = 2'd0;
    localparam logic [1:0] S_OUT = 2'd1;
    localparam logic [1:0] S_ERR = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    first_q, first_d;
    logic [CW-1:0]    index_q, index_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [SYM_W-1:0] sym_out_q, sym_out_d;

    logic [7:0]       cnt_q [1:MAX_LEN];
    logic [SYM_W-1:0] sym_q [0:NSYM-1];

    logic [7:0]       cnt_cur;
    logic [CW-1:0]    c;
    logic [XW-1:0]    lim;
    logic [XW-1:0]    idx;
    logic             match;
    logic             oor;
    logic             accept;

    // count[len] through a compare mux so len never indexes outside 1..MAX_LEN
    always_comb begin
        cnt_cur = '0;
        for (int k = 1; k <= MAX_LEN; k++) begin
            if (len_q == LEN_W'(k)) cnt_cur = cnt_q[k];
        end
    end

    assign c      = CW'({code_q, bit_in});
    assign lim    = XW'(first_q) + XW'(cnt_cur);
    assign match  = XW'(c) < lim;
    assign idx    = XW'(index_q) + XW'(c) - XW'(first_q);
    assign oor    = idx >= XW'(NSYM);

    assign bit_ready = (state_q == S_BIT) && !cfg_we && !start;
    assign accept    = bit_valid && bit_ready;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        first_d   = first_q;
        index_d   = index_q;
        len_d     = len_q;
        sym_out_d = sym_out_q;
        if (start) begin
            state_d = S_BIT;
            code_d  = '0;
            first_d = '0;
            index_d = '0;
            len_d   = LEN_W'(1);
        end else begin
            case (state_q)
                S_BIT: begin
                    if (accept) begin
                        if (match) begin
                            if (oor) begin
                                state_d = S_ERR;
                            end else begin
                                sym_out_d = sym_q[idx[SA_W-1:0]];
                                state_d   = S_OUT;
                            end
                        end else if (len_q == LEN_W'(MAX_LEN)) begin
                            state_d = S_ERR;
                        end else begin
                            index_d = index_q + CW'(cnt_cur);
                            first_d = {lim[CW-2:0], 1'b0};
                            code_d  = c;
                            len_d   = len_q + LEN_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (sym_ready) begin
                        state_d = S_BIT;
                        code_d  = '0;
                        first_d = '0;
                        index_d = '0;
                        len_d   = LEN_W'(1);
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_BIT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_BIT;
            code_q    <= '0;
            first_q   <= '0;
            index_q   <= '0;
            len_q     <= LEN_W'(1);
            sym_out_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            first_q   <= first_d;
            index_q   <= index_d;
            len_q     <= len_d;
            sym_out_q <= sym_out_d;
        end
    end

    // Table writes; out-of-range addresses simply match no entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 1; k <= MAX_LEN; k++) cnt_q[k] <= '0;
            for (int k = 0; k < NSYM; k++)     sym_q[k] <= '0;
        end else if (cfg_we) begin
            if (!cfg_sel) begin
                for (int k = 1; k <= MAX_LEN; k++) begin
                    if (cfg_addr == 4'(k)) cnt_q[k] <= cfg_data;
                end
            end else begin
                for (int k = 0; k < NSYM; k++) begin
                    if (cfg_addr == 4'(k)) sym_q[k] <= SYM_W'(cfg_data);
                end
            end
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = (state_q == S_OUT);
    assign err       = (state_q == S_ERR);
    assign busy      = (len_q != LEN_W'(1)) || (state_q != S_BIT);

endmodule
